// File: rtl/key_set_controller.sv
// Button front end for the digital clock: two-flop synchronisers, debounce,
// press-edge detection, field selection and INC auto-repeat. The outputs are
// single-cycle increment pulses for the sec/min/hour counters and a field LED.
module key_set_controller #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 25_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000
) (
   input  logic       clock_50_i,
   input  logic       reset_n_i,
   input  logic       key_mode_n_i,
   input  logic       key_inc_n_i,
   input  logic       set_en_i,
   output logic [1:0] sel_count_o,
   output logic       inc_sec_o,
   output logic       inc_min_o,
   output logic       inc_hour_o,
   output logic [2:0] sel_led_o
);
   localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] RPT_LOAD  = TMR_W'(REPEAT_CYCLES - 1);
   localparam int K_MODE = 0;
   localparam int K_INC  = 1;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RPT, ST_WAIT_REL} state_t;

   logic [1:0]       key_raw_n;
   logic [1:0]       deb_lvl;    // debounced level, 1 = released
   logic [1:0]       press_evt;  // one-cycle press strobe per key
   logic [1:0]       sel_count_q, sel_count_d;
   state_t           state_q;
   logic [TMR_W-1:0] timer_q;
   logic [2:0]       inc_q;      // {hour, min, sec}
   logic [2:0]       sel_led_d;

   assign key_raw_n = {key_inc_n_i, key_mode_n_i};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_key
         logic             sync1_q, sync2_q, deb_q, deb_d1_q, press_q;
         logic [DEB_W-1:0] cnt_q;

         // Two-flop synchroniser; everything downstream sees only sync2_q.
         always_ff @(posedge clock_50_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               sync1_q <= 1'b1;
               sync2_q <= 1'b1;
            end else begin
               sync1_q <= key_raw_n[gi];
               sync2_q <= sync1_q;
            end
         end

         // Accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
         always_ff @(posedge clock_50_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               cnt_q <= '0;
               deb_q <= 1'b1;
            end else if (sync2_q == deb_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
               deb_q <= sync2_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         // Registered 1->0 edge of the debounced level gives the press strobe.
         always_ff @(posedge clock_50_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               deb_d1_q <= 1'b1;
               press_q  <= 1'b0;
            end else begin
               deb_d1_q <= deb_q;
               press_q  <= deb_d1_q & ~deb_q;
            end
         end

         assign deb_lvl[gi]   = deb_q;
         assign press_evt[gi] = press_q;
      end
   endgenerate

   // One-hot pulse target for the currently selected field.
   function automatic logic [2:0] route(input logic [1:0] sel);
      case (sel)
         2'd0:    route = 3'b001;
         2'd1:    route = 3'b010;
         2'd2:    route = 3'b100;
         default: route = 3'b000;
      endcase
   endfunction

   // Field selection: MODE cycles 0->1->2->0; leaving set mode parks it on sec.
   always_comb begin
      sel_count_d = sel_count_q;
      if (!set_en_i) begin
         sel_count_d = 2'd0;
      end else if (press_evt[K_MODE]) begin
         sel_count_d = (sel_count_q == 2'd2) ? 2'd0 : sel_count_q + 2'd1;
      end
   end

   // Selection register.
   always_ff @(posedge clock_50_i or negedge reset_n_i) begin
      if (!reset_n_i) sel_count_q <= 2'd0;
      else            sel_count_q <= sel_count_d;
   end

   // INC auto-repeat FSM; pulses route on the pre-update selection, so a
   // simultaneous MODE press only affects later pulses.
   always_ff @(posedge clock_50_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         inc_q   <= 3'b000;
      end else begin
         inc_q <= 3'b000;
         case (state_q)
            ST_IDLE: begin
               if (press_evt[K_INC] && set_en_i) begin
                  inc_q   <= route(sel_count_q);
                  timer_q <= HOLD_LOAD;
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD, ST_RPT: begin
               if (deb_lvl[K_INC]) begin
                  state_q <= ST_IDLE;
               end else if (!set_en_i) begin
                  state_q <= ST_WAIT_REL;
               end else if (timer_q == '0) begin
                  inc_q   <= route(sel_count_q);
                  timer_q <= RPT_LOAD;
                  state_q <= ST_RPT;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            ST_WAIT_REL: begin
               // A held key must be released before set mode can repeat again.
               if (deb_lvl[K_INC]) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Field LED: thermometer code of the selection, dark outside set mode and in reset.
   always_comb begin
      sel_led_d = 3'b000;
      if (reset_n_i && set_en_i) begin
         case (sel_count_q)
            2'd0:    sel_led_d = 3'b001;
            2'd1:    sel_led_d = 3'b011;
            2'd2:    sel_led_d = 3'b111;
            default: sel_led_d = 3'b000;
         endcase
      end
   end

   assign sel_count_o = sel_count_q;
   assign inc_sec_o   = inc_q[0];
   assign inc_min_o   = inc_q[1];
   assign inc_hour_o  = inc_q[2];
   assign sel_led_o   = sel_led_d;
endmodule

// File: tb/tb_key_set_controller.sv
// Bench for key_set_controller with short debounce/hold/repeat times.
// Directed table and sequences plus random key waveforms checked every cycle
// against an event-level reference model.
module tb_key_set_controller;
   localparam int DEB  = 4;
   localparam int HOLD = 20;
   localparam int RPT  = 8;
   localparam int MAXC = 16384;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_mode_n = 1'b1;
   logic       key_inc_n = 1'b1;
   logic       set_en = 1'b1;
   logic [1:0] sel;
   logic       inc_sec, inc_min, inc_hour;
   logic [2:0] led;

   always #5 clk = ~clk;

   key_set_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (RPT)
   ) dut (
      .clock_50_i  (clk),
      .reset_n_i   (rst_n),
      .key_mode_n_i(key_mode_n),
      .key_inc_n_i (key_inc_n),
      .set_en_i    (set_en),
      .sel_count_o (sel),
      .inc_sec_o   (inc_sec),
      .inc_min_o   (inc_min),
      .inc_hour_o  (inc_hour),
      .sel_led_o   (led)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Histories indexed by clock edge since reset release (edge 1 = first edge).
   bit raw_h [2][MAXC];   // raw key level sampled at each edge (0 = MODE, 1 = INC)
   bit deb_h [2][MAXC];   // accepted level after each edge
   int n;
   int m_mode;            // 0 idle, 1 key held and repeating, 2 waiting for release
   int m_ts;              // edge of the first pulse of the current hold
   int m_sel;
   bit model_on = 1'b0;

   task automatic model_reset();
      n = 0;
      deb_h[0][0] = 1'b1;
      deb_h[1][0] = 1'b1;
      m_mode = 0;
      m_ts = 0;
      m_sel = 0;
   endtask

   function automatic bit deb_at(input int k, input int i);
      return (i <= 0) ? 1'b1 : deb_h[k][i];
   endfunction

   // Level seen by the debouncer at edge m: raw level from two edges earlier.
   function automatic bit sync_at(input int k, input int m);
      return (m - 2 < 1) ? 1'b1 : raw_h[k][m - 2];
   endfunction

   // Directed-test observation
   int pulses[3];
   int first_t;
   int cyc;

   task automatic count_reset();
      pulses[0] = 0; pulses[1] = 0; pulses[2] = 0;
      first_t = -1;
      cyc = 0;
   endtask

   // Advance one clock; inputs seen at this edge are the ones driven now.
   task automatic run_cycle();
      bit rm, ri, e, flip, pm, pi, rel, fire;
      int d, exp_inc, exp_led, act;
      rm = key_mode_n;
      ri = key_inc_n;
      e  = set_en;
      @(posedge clk);
      #1;
      if (model_on && n < MAXC - 1) begin
         n++;
         raw_h[0][n] = rm;
         raw_h[1][n] = ri;
         for (int k = 0; k < 2; k++) begin
            // Level flips once the last DEB seen samples all disagree with it.
            flip = (n - DEB + 1 >= 1);
            for (int j = n - DEB + 1; j <= n; j++)
               if (j >= 1 && sync_at(k, j) == deb_h[k][n - 1]) flip = 1'b0;
            deb_h[k][n] = flip ? !deb_h[k][n - 1] : deb_h[k][n - 1];
         end
         pm  = deb_at(0, n - 3) && !deb_at(0, n - 2);
         pi  = deb_at(1, n - 3) && !deb_at(1, n - 2);
         rel = deb_at(1, n - 1);
         fire = 1'b0;
         case (m_mode)
            0: if (pi && e) begin fire = 1'b1; m_mode = 1; m_ts = n; end
            1: begin
               if (rel) m_mode = 0;
               else if (!e) m_mode = 2;
               else begin
                  d = n - m_ts;
                  if (d >= HOLD && (d - HOLD) % RPT == 0) fire = 1'b1;
               end
            end
            default: if (rel) m_mode = 0;
         endcase
         exp_inc = fire ? (1 << m_sel) : 0;
         if (!e) m_sel = 0;
         else if (pm) m_sel = (m_sel + 1) % 3;
         exp_led = e ? ((1 << (m_sel + 1)) - 1) : 0;
         act = int'({sel, inc_hour, inc_min, inc_sec, led});
         check("model_cycle", act, (m_sel << 6) | (exp_inc << 3) | exp_led);
      end
      if (inc_sec)  pulses[0]++;
      if (inc_min)  pulses[1]++;
      if (inc_hour) pulses[2]++;
      if ((inc_sec || inc_min || inc_hour) && first_t < 0) first_t = cyc;
      cyc++;
   endtask

   task automatic hold_inc(input int len, input int tail);
      key_inc_n = 1'b0;
      count_reset();
      repeat (len) run_cycle();
      key_inc_n = 1'b1;
      repeat (tail) run_cycle();
   endtask

   task automatic press_mode();
      key_mode_n = 1'b0;
      repeat (8) run_cycle();
      key_mode_n = 1'b1;
      repeat (12) run_cycle();
   endtask

   typedef struct {
      string name;
      bit    en;
      int    hold;
      int    exp_n;
      int    exp_first;
   } vec_t;

   vec_t tbl[7];
   int exp_sel_seq[3];
   int exp_led_seq[3];

   initial begin
      tbl[0] = '{"hold3",   1'b1, 3,  0, -1};
      tbl[1] = '{"hold4",   1'b1, 4,  1,  7};
      tbl[2] = '{"hold10",  1'b1, 10, 1,  7};
      tbl[3] = '{"hold28",  1'b1, 28, 2,  7};
      tbl[4] = '{"hold36",  1'b1, 36, 3,  7};
      tbl[5] = '{"hold60",  1'b1, 60, 6,  7};
      tbl[6] = '{"dis30",   1'b0, 30, 0, -1};
      exp_sel_seq = '{1, 2, 0};
      exp_led_seq = '{3, 7, 1};

      // Reset state
      count_reset();
      repeat (3) run_cycle();
      check("reset_outs", int'({sel, inc_hour, inc_min, inc_sec}), 0);
      check("reset_led", int'(led), 0);
      rst_n = 1'b1;
      model_reset();
      model_on = 1'b1;
      repeat (10) run_cycle();
      check("post_reset_led", int'(led), 1);

      // Hold-length table, selection on sec
      for (int i = 0; i < 7; i++) begin
         set_en = tbl[i].en;
         repeat (2) run_cycle();
         hold_inc(tbl[i].hold, 15);
         check({tbl[i].name, "_count"}, pulses[0] + pulses[1] + pulses[2], tbl[i].exp_n);
         check({tbl[i].name, "_first"}, first_t, tbl[i].exp_first);
         check({tbl[i].name, "_field"}, pulses[1] + pulses[2], 0);
         set_en = 1'b1;
         repeat (5) run_cycle();
      end

      // Bounce: short low runs must never be accepted
      count_reset();
      key_inc_n = 1'b0; repeat (3) run_cycle();
      key_inc_n = 1'b1; repeat (2) run_cycle();
      key_inc_n = 1'b0; repeat (3) run_cycle();
      key_inc_n = 1'b1; repeat (15) run_cycle();
      check("bounce_inc", pulses[0] + pulses[1] + pulses[2], 0);
      key_mode_n = 1'b0; repeat (3) run_cycle();
      key_mode_n = 1'b1; repeat (10) run_cycle();
      check("bounce_mode_sel", int'(sel), 0);

      // MODE sequence and routing of a following INC press
      for (int i = 0; i < 3; i++) begin
         press_mode();
         check($sformatf("mode%0d_sel", i), int'(sel), exp_sel_seq[i]);
         check($sformatf("mode%0d_led", i), int'(led), exp_led_seq[i]);
         hold_inc(10, 15);
         check($sformatf("mode%0d_target", i), pulses[exp_sel_seq[i]], 1);
         check($sformatf("mode%0d_total", i), pulses[0] + pulses[1] + pulses[2], 1);
      end

      // Simultaneous MODE and INC presses: pulse uses the old field
      key_mode_n = 1'b0;
      key_inc_n = 1'b0;
      count_reset();
      repeat (10) run_cycle();
      key_mode_n = 1'b1;
      key_inc_n = 1'b1;
      repeat (15) run_cycle();
      check("simul_sec", pulses[0], 1);
      check("simul_min", pulses[1], 0);
      check("simul_sel", int'(sel), 1);

      // MODE press during repeat retargets later pulses (min -> hour)
      key_inc_n = 1'b0;
      count_reset();
      repeat (30) run_cycle();
      key_mode_n = 1'b0; repeat (8) run_cycle();
      key_mode_n = 1'b1; repeat (22) run_cycle();
      key_inc_n = 1'b1;
      repeat (15) run_cycle();
      check("retarget_min", pulses[1], 3);
      check("retarget_hour", pulses[2], 3);
      check("retarget_sec", pulses[0], 0);

      // set_en dropped during repeat, then restored with INC still held
      key_inc_n = 1'b0;
      count_reset();
      repeat (40) run_cycle();
      check("rpt_before_drop", pulses[2], 3);
      set_en = 1'b0;
      count_reset();
      repeat (20) run_cycle();
      check("drop_pulses", pulses[0] + pulses[1] + pulses[2], 0);
      check("drop_sel", int'(sel), 0);
      check("drop_led", int'(led), 0);
      set_en = 1'b1;
      count_reset();
      repeat (30) run_cycle();
      check("restore_held_pulses", pulses[0] + pulses[1] + pulses[2], 0);
      key_inc_n = 1'b1;
      repeat (15) run_cycle();
      hold_inc(10, 15);
      check("repress_sec", pulses[0], 1);
      check("repress_first", first_t, 7);

      // Reset asserted mid-run with INC held in repeat
      press_mode();
      key_inc_n = 1'b0;
      count_reset();
      repeat (40) run_cycle();
      rst_n = 1'b0;
      model_on = 1'b0;
      #1;
      check("midrst_outs", int'({sel, inc_hour, inc_min, inc_sec}), 0);
      check("midrst_led", int'(led), 0);
      repeat (3) run_cycle();
      check("midrst_hold_outs", int'({sel, inc_hour, inc_min, inc_sec, led}), 0);
      key_inc_n = 1'b1;
      repeat (3) run_cycle();
      rst_n = 1'b1;
      model_reset();
      model_on = 1'b1;
      count_reset();
      repeat (30) run_cycle();
      check("midrst_quiet", pulses[0] + pulses[1] + pulses[2], 0);
      hold_inc(10, 15);
      check("midrst_press_sec", pulses[0], 1);
      check("midrst_press_first", first_t, 7);

      // Random key waveforms against the model
      for (int s = 0; s < 80; s++) begin
         key_inc_n  = ($urandom_range(0, 1) == 0);
         key_mode_n = ($urandom_range(0, 9) >= 3);
         set_en     = ($urandom_range(0, 19) >= 3);
         repeat ($urandom_range(1, 30)) run_cycle();
      end
      key_inc_n = 1'b1;
      key_mode_n = 1'b1;
      set_en = 1'b1;
      repeat (20) run_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
